// File: rtl/dram_arb_pkg.sv
// -----------------------------------------------------------------------------
// dram_arb_pkg
// Shared types and constants for the data-RAM arbiter slice.
//   owner_t   : identifies who owns / last owned / is reading the RAM port
//   BYTE_EN_W : width of the byte-enable buses
//   REQ_HOST / REQ_CPU : bit positions of each requester in the 2-bit vectors
// -----------------------------------------------------------------------------
package dram_arb_pkg;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_HOST = 2'd1,
        OWN_CPU  = 2'd2
    } owner_t;

    localparam int BYTE_EN_W = 4;

    localparam int REQ_HOST = 0;
    localparam int REQ_CPU  = 1;

    // Map a requester bit position onto its owner encoding.
    function automatic owner_t idx_owner(input logic is_cpu);
        return is_cpu ? OWN_CPU : OWN_HOST;
    endfunction

endpackage

// File: rtl/dram_arb_rr2.sv
// -----------------------------------------------------------------------------
// arb_rr2
// Two-way round-robin arbiter with a bounded ownership lock and an exclusive
// mode that reserves the port for requester 0 (host).
// Ports:
//   clk_i, rst_n_i : clock, asynchronous active-low reset
//   req_i[1:0]     : requests (bit 0 host, bit 1 CPU)
//   lock_i[1:0]    : per-requester "keep ownership after this access"
//   excl_i         : exclusive mode, requester 1 is never granted
//   gnt_o[1:0]     : one-hot (or zero) grant, combinational
//   winner_o       : owner encoding of the granted requester this cycle
// -----------------------------------------------------------------------------
module arb_rr2
    import dram_arb_pkg::*;
#(
    parameter int LOCK_MAX = 16
) (
    input  logic       clk_i,
    input  logic       rst_n_i,
    input  logic [1:0] req_i,
    input  logic [1:0] lock_i,
    input  logic       excl_i,
    output logic [1:0] gnt_o,
    output owner_t     winner_o
);

    // The counter never exceeds LOCK_MAX-1, so clog2(LOCK_MAX) bits suffice.
    localparam int               CNT_W   = (LOCK_MAX > 1) ? $clog2(LOCK_MAX) : 1;
    localparam logic [CNT_W-1:0] CNT_LIM = CNT_W'(LOCK_MAX - 1);

    owner_t           r_last_own;
    owner_t           r_lock_own;
    logic [CNT_W-1:0] r_lock_cnt;

    owner_t           w_last_own_next;
    owner_t           w_lock_own_next;
    logic [CNT_W-1:0] w_lock_cnt_next;

    logic [1:0]       w_gnt;
    owner_t           w_winner;
    logic             w_win_lock;
    logic [CNT_W-1:0] w_cnt_base;

    // -------------------------------------------------------------------------
    // Grant selection. Outputs are held at zero while reset is asserted so a
    // requester cannot see an accepted access during reset.
    // -------------------------------------------------------------------------
    always_comb begin
        w_gnt = 2'b00;
        if (!rst_n_i) begin
            w_gnt = 2'b00;
        end else if (excl_i) begin
            w_gnt[REQ_HOST] = req_i[REQ_HOST];
        end else if (r_lock_own == OWN_HOST && req_i[REQ_HOST]) begin
            w_gnt[REQ_HOST] = 1'b1;
        end else if (r_lock_own == OWN_CPU && req_i[REQ_CPU]) begin
            w_gnt[REQ_CPU] = 1'b1;
        end else if (&req_i) begin
            // Contested: whoever did not go last gets the port.
            if (r_last_own == OWN_CPU) begin
                w_gnt[REQ_HOST] = 1'b1;
            end else begin
                w_gnt[REQ_CPU] = 1'b1;
            end
        end else begin
            w_gnt = req_i;
        end
    end

    always_comb begin
        w_winner   = OWN_NONE;
        w_win_lock = 1'b0;
        if (w_gnt[REQ_CPU]) begin
            w_winner   = OWN_CPU;
            w_win_lock = lock_i[REQ_CPU];
        end else if (w_gnt[REQ_HOST]) begin
            w_winner   = OWN_HOST;
            w_win_lock = lock_i[REQ_HOST];
        end
    end

    // -------------------------------------------------------------------------
    // Next-state: a fresh owner starts counting from zero. This also covers
    // exclusive mode overriding a CPU lock: the host wins, so the CPU lock is
    // discarded at this edge. Any cycle without an accepted access drops the
    // lock, which handles the owner releasing its request.
    // -------------------------------------------------------------------------
    always_comb begin
        w_last_own_next = r_last_own;
        w_lock_own_next = OWN_NONE;
        w_lock_cnt_next = '0;
        w_cnt_base      = (r_lock_own == w_winner) ? r_lock_cnt : '0;
        if (w_winner != OWN_NONE) begin
            w_last_own_next = w_winner;
            if (w_win_lock && (w_cnt_base < CNT_LIM)) begin
                w_lock_own_next = w_winner;
                w_lock_cnt_next = w_cnt_base + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_last_own <= OWN_HOST;
            r_lock_own <= OWN_NONE;
            r_lock_cnt <= '0;
        end else begin
            r_last_own <= w_last_own_next;
            r_lock_own <= w_lock_own_next;
            r_lock_cnt <= w_lock_cnt_next;
        end
    end

    assign gnt_o    = w_gnt;
    assign winner_o = w_winner;

endmodule

// File: rtl/dram_arb.sv
// -----------------------------------------------------------------------------
// dram_arb
// Shares the single data-RAM port between the host loader and the CPU data
// interface. One access per cycle, zero-cycle grant, read data returned one
// cycle later to whichever requester issued the read.
// Ports:
//   clk_i, rst_n_i        : clock, asynchronous active-low reset
//   host_excl_i           : host-exclusive mode (CPU never granted)
//   h_* / c_* inputs      : request bundles (req, lock, we, addr, wdata, byte_en)
//   h_* / c_* outputs     : grant, read data, read-data valid
//   ram_*_o               : RAM strobe, write enable, address, data, byte enables
//   ram_rdata_i           : RAM read data, valid one cycle after a read strobe
// -----------------------------------------------------------------------------
module dram_arb
    import dram_arb_pkg::*;
#(
    parameter int XLEN     = 32,
    parameter int LOCK_MAX = 16
) (
    input  logic                 clk_i,
    input  logic                 rst_n_i,
    input  logic                 host_excl_i,

    input  logic                 h_req_i,
    input  logic                 h_lock_i,
    input  logic                 h_we_i,
    input  logic [XLEN-1:0]      h_addr_i,
    input  logic [XLEN-1:0]      h_wdata_i,
    input  logic [BYTE_EN_W-1:0] h_byte_en_i,
    output logic                 h_gnt_o,
    output logic [XLEN-1:0]      h_rdata_o,
    output logic                 h_rvld_o,

    input  logic                 c_req_i,
    input  logic                 c_lock_i,
    input  logic                 c_we_i,
    input  logic [XLEN-1:0]      c_addr_i,
    input  logic [XLEN-1:0]      c_wdata_i,
    input  logic [BYTE_EN_W-1:0] c_byte_en_i,
    output logic                 c_gnt_o,
    output logic [XLEN-1:0]      c_rdata_o,
    output logic                 c_rvld_o,

    output logic                 ram_en_o,
    output logic                 ram_we_o,
    output logic [XLEN-1:0]      ram_addr_o,
    output logic [XLEN-1:0]      ram_wdata_o,
    output logic [BYTE_EN_W-1:0] ram_byte_en_o,
    input  logic [XLEN-1:0]      ram_rdata_i
);

    // Requester-indexed views of the two bundles (0 = host, 1 = CPU).
    logic [1:0]           w_req;
    logic [1:0]           w_lock;
    logic [1:0]           w_we;
    logic [XLEN-1:0]      w_addr    [2];
    logic [XLEN-1:0]      w_wdata   [2];
    logic [BYTE_EN_W-1:0] w_byte_en [2];
    logic [1:0]           w_gnt;
    logic [1:0]           w_rvld;
    logic [XLEN-1:0]      w_rdata   [2];
    owner_t               w_winner;
    logic                 w_sel;

    owner_t               r_rd_tag;

    assign w_req  = {c_req_i,  h_req_i};
    assign w_lock = {c_lock_i, h_lock_i};
    assign w_we   = {c_we_i,   h_we_i};

    assign w_addr[REQ_HOST]    = h_addr_i;
    assign w_addr[REQ_CPU]     = c_addr_i;
    assign w_wdata[REQ_HOST]   = h_wdata_i;
    assign w_wdata[REQ_CPU]    = c_wdata_i;
    assign w_byte_en[REQ_HOST] = h_byte_en_i;
    assign w_byte_en[REQ_CPU]  = c_byte_en_i;

    arb_rr2 #(
        .LOCK_MAX (LOCK_MAX)
    ) u_arb (
        .clk_i    (clk_i),
        .rst_n_i  (rst_n_i),
        .req_i    (w_req),
        .lock_i   (w_lock),
        .excl_i   (host_excl_i),
        .gnt_o    (w_gnt),
        .winner_o (w_winner)
    );

    // Grants are one-hot, so the CPU grant bit alone selects the bundle.
    assign w_sel = w_gnt[REQ_CPU];

    // -------------------------------------------------------------------------
    // RAM port mux. Idle cycles drive all-zero so the RAM sees clean buses.
    // Byte enables are suppressed on reads.
    // -------------------------------------------------------------------------
    always_comb begin
        ram_en_o      = 1'b0;
        ram_we_o      = 1'b0;
        ram_addr_o    = '0;
        ram_wdata_o   = '0;
        ram_byte_en_o = '0;
        if (|w_gnt) begin
            ram_en_o    = 1'b1;
            ram_we_o    = w_we[w_sel];
            ram_addr_o  = w_addr[w_sel];
            ram_wdata_o = w_wdata[w_sel];
            if (w_we[w_sel]) begin
                ram_byte_en_o = w_byte_en[w_sel];
            end
        end
    end

    // -------------------------------------------------------------------------
    // Read-tag pipeline: remembers who issued the read so the RAM's one-cycle
    // data can be steered back. Async reset drops a pending response at once.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_rd_tag <= OWN_NONE;
        end else if (ram_en_o && !ram_we_o) begin
            r_rd_tag <= w_winner;
        end else begin
            r_rd_tag <= OWN_NONE;
        end
    end

    for (genvar gi = 0; gi < 2; gi++) begin : g_resp
        assign w_rvld[gi]  = (r_rd_tag == idx_owner(1'(gi)));
        assign w_rdata[gi] = w_rvld[gi] ? ram_rdata_i : '0;
    end

    assign h_gnt_o   = w_gnt[REQ_HOST];
    assign c_gnt_o   = w_gnt[REQ_CPU];
    assign h_rvld_o  = w_rvld[REQ_HOST];
    assign c_rvld_o  = w_rvld[REQ_CPU];
    assign h_rdata_o = w_rdata[REQ_HOST];
    assign c_rdata_o = w_rdata[REQ_CPU];

endmodule

// File: doc/dram_arb.md
Name: dram_arb

Overview:
- Two-requester arbiter sharing the single data-RAM port between the host loader (UART command path) and the hxd32 CPU data interface.
- Grants one access per cycle with round-robin fairness and an optional bounded burst lock.
- Host-exclusive mode gives the loader the RAM while the CPU is held in reset.
- Routes 1-cycle-latency read data back to the requester that issued the read.

Parameters:
XLEN, 32, address/data width
LOCK_MAX, 16, max consecutive locked grants before forced release (>=1)

Ports:
clk_i  in  1  system clock
rst_n_i  in  1  reset, asynchronous, active-low
host_excl_i  in  1  host-exclusive mode; CPU never granted while high
h_req_i  in  1  host access request
h_lock_i  in  1  host requests to keep ownership after this access
h_we_i  in  1  host write (1) / read (0)
h_addr_i  in  XLEN  host byte address
h_wdata_i  in  XLEN  host write data
h_byte_en_i  in  4  host write byte enables
h_gnt_o  out  1  host access accepted this cycle
h_rdata_o  out  XLEN  host read data
h_rvld_o  out  1  host read data valid
c_req_i, c_lock_i, c_we_i, c_addr_i, c_wdata_i, c_byte_en_i  in  (as host)  CPU request bundle
c_gnt_o, c_rdata_o, c_rvld_o  out  (as host)  CPU response bundle
ram_en_o  out  1  RAM access strobe
ram_we_o  out  1  RAM write enable
ram_addr_o  out  XLEN  RAM address
ram_wdata_o  out  XLEN  RAM write data
ram_byte_en_o  out  4  RAM byte enables (4'b0000 on reads)
ram_rdata_i  in  XLEN  RAM read data, valid 1 cycle after read strobe

Behaviour:
- Reset (async):
  - last_own=HOST, lock_own=NONE, lock_cnt=0, rd_tag=NONE.
  - All gnt/rvld outputs 0; ram_en_o/ram_we_o 0; ram_addr_o, ram_wdata_o, ram_byte_en_o, both rdata outputs 0.
- Grants are combinational from registered state and the current req inputs.
  - An access is accepted in the cycle where req && gnt.
  - At most one gnt high per cycle.
- Priority, evaluated each cycle in order:
  1. host_excl_i=1: host wins if h_req_i; CPU gnt forced 0.
  2. lock_own!=NONE and that owner's req high: owner wins.
  3. Both requesting: the owner != last_own wins (round-robin).
  4. Single requester wins.
- RAM outputs:
  - Muxed from the winner combinationally.
  - ram_en_o = any gnt; ram_we_o = winner we & ram_en_o.
  - With no winner, ram_en_o=0 and the other RAM outputs are 0.
- On each accepted access:
  - last_own <= winner.
  - If winner lock_i=1 and lock_cnt < LOCK_MAX-1: lock_own <= winner, lock_cnt++. Otherwise lock_own <= NONE, lock_cnt <= 0.
- Lock release:
  - Lock also drops (lock_own <= NONE, cnt <= 0) in any cycle where the owner's req is low.
  - Forced release at LOCK_MAX makes the next contested cycle go to the other requester via round-robin.
- host_excl_i rising clears any CPU lock in the same cycle.
- Read return:
  - Accepted read sets rd_tag <= winner; otherwise rd_tag <= NONE.
  - Next cycle, rvld_o of the rd_tag owner = 1 and its rdata_o = ram_rdata_i.
  - The other rdata_o holds 0.
  - Back-to-back reads from alternating owners return correctly tagged.
- Writes produce no response beyond gnt.
- Requests must hold stable until gnt; the arbiter does not buffer them.
- Reset mid-access: a pending rvld is dropped; no response is issued after reset.
- Latency: grant 0 cycles; read data 1 cycle after grant.

Decomposition:
- Shared package dram_arb_pkg:
  - owner_t enum {OWN_NONE, OWN_HOST, OWN_CPU}.
  - BYTE_EN_W=4 constant.
- Sub-module arb_rr2: 2-way round-robin with lock and counter.
  - Inputs: req[1:0], lock[1:0], excl.
  - Outputs: gnt[1:0], owner state.
- dram_arb wraps arb_rr2 with the RAM mux and read-tag pipeline.

Test Plan:
- Reset, then host read 0x0000_0010, RAM returns 0xDEAD_BEEF -> h_gnt_o same cycle, h_rvld_o=1 with h_rdata_o=0xDEAD_BEEF next cycle; c_rvld_o=0.
- Both req every cycle, no lock, last_own=HOST -> grants alternate CPU, HOST, CPU, HOST; never both high.
- CPU req+lock held, host req held, LOCK_MAX=4 -> 4 consecutive CPU grants, then host granted on the 5th cycle.
- host_excl_i=1, c_req_i=1 for 20 cycles, h_req_i idle -> c_gnt_o stays 0, ram_en_o stays 0; host write 0x8000_0000/0x1234_5678/4'b0011 passes through unchanged.
- Host read at cycle N, CPU read at N+1 -> h_rvld_o at N+1, c_rvld_o at N+2, each carrying the RAM data of its own address.
- rst_n_i asserted the cycle after an accepted CPU read -> c_rvld_o stays 0; all outputs 0 during reset; first post-reset contested grant goes to the CPU.
